// File: rtl/mem1_pkg.sv
// Shared definitions for the MEM1 data-access stage: FSM state codes,
// word-offset width and the memory-operation decode with load-over-store priority.
package mem1_pkg;

  localparam int WORD_OFFSET_BITS = 3;

  typedef logic [1:0] state_t;
  localparam state_t IDLE      = 2'd0;
  localparam state_t REQ       = 2'd1;
  localparam state_t WAIT_RESP = 2'd2;

  typedef logic [1:0] mem_op_t;
  localparam mem_op_t OP_ALU   = 2'd0;
  localparam mem_op_t OP_LOAD  = 2'd1;
  localparam mem_op_t OP_STORE = 2'd2;

  // A load wins when both flags are set.
  function automatic mem_op_t decode_op(input logic load_flag, input logic store_flag);
    mem_op_t op_s;
    if (load_flag) begin
      op_s = OP_LOAD;
    end else if (store_flag) begin
      op_s = OP_STORE;
    end else begin
      op_s = OP_ALU;
    end
    return op_s;
  endfunction

endpackage

// File: rtl/mem1_result_register.sv
// Valid/ready holding register for MEM1 results; holds out_* while stalled downstream.
// MEM1_ALIGN_CHECK_EN adds the misaligned flag to the held result.
module mem1_result_register #(
  parameter int DATA_WIDTH        = 64,
  parameter int REG_INDEX_BITS    = 5,
  parameter int THREAD_INDEX_BITS = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         res_load,
  input  logic                         res_write_enable,
  input  logic [THREAD_INDEX_BITS-1:0] res_thread_index,
  input  logic [REG_INDEX_BITS-1:0]    res_reg_index,
  input  logic [DATA_WIDTH-1:0]        res_data,
`ifdef MEM1_ALIGN_CHECK_EN
  input  logic                         res_misaligned,
  output logic                         out_misaligned,
`endif
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic                         out_write_enable,
  output logic [THREAD_INDEX_BITS-1:0] out_thread_index,
  output logic [REG_INDEX_BITS-1:0]    out_reg_index,
  output logic [DATA_WIDTH-1:0]        out_data
);

  logic                         valid_r;
  logic                         write_enable_r;
  logic [THREAD_INDEX_BITS-1:0] thread_index_r;
  logic [REG_INDEX_BITS-1:0]    reg_index_r;
  logic [DATA_WIDTH-1:0]        data_r;
`ifdef MEM1_ALIGN_CHECK_EN
  logic                         misaligned_r;
`endif

  // Load a new result, otherwise retire the held one once downstream takes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r        <= 1'b0;
      write_enable_r <= 1'b0;
      thread_index_r <= {THREAD_INDEX_BITS{1'b0}};
      reg_index_r    <= {REG_INDEX_BITS{1'b0}};
      data_r         <= {DATA_WIDTH{1'b0}};
`ifdef MEM1_ALIGN_CHECK_EN
      misaligned_r   <= 1'b0;
`endif
    end else if (res_load) begin
      valid_r        <= 1'b1;
      write_enable_r <= res_write_enable;
      thread_index_r <= res_thread_index;
      reg_index_r    <= res_reg_index;
      data_r         <= res_data;
`ifdef MEM1_ALIGN_CHECK_EN
      misaligned_r   <= res_misaligned;
`endif
    end else if (out_ready) begin
      valid_r <= 1'b0;
    end
  end

  assign out_valid        = valid_r;
  assign out_write_enable = write_enable_r;
  assign out_thread_index = thread_index_r;
  assign out_reg_index    = reg_index_r;
  assign out_data         = data_r;
`ifdef MEM1_ALIGN_CHECK_EN
  assign out_misaligned   = misaligned_r;
`endif

endmodule

// File: rtl/mem1_data_access.sv
// MEM1 pipeline stage: ALU pass-through or one data-memory load/store per instruction.
// Optional MEM1_ALIGN_CHECK_EN short-circuits misaligned accesses and adds out_misaligned.
module mem1_data_access
  import mem1_pkg::*;
#(
  parameter int DATA_WIDTH        = 64,
  parameter int REG_INDEX_BITS    = 5,
  parameter int THREAD_INDEX_BITS = 3,
  parameter int ADDR_WIDTH        = 10,
  parameter int STALL_COUNT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_load_word_flag,
  input  logic                         in_store_word_flag,
  input  logic [THREAD_INDEX_BITS-1:0] in_thread_index,
  input  logic [REG_INDEX_BITS-1:0]    in_reg_index,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [DATA_WIDTH-1:0]        in_store_data,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic                         mem_req_write,
  output logic [ADDR_WIDTH-1:0]        mem_req_addr,
  output logic [DATA_WIDTH-1:0]        mem_req_wdata,
  input  logic                         mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]        mem_resp_rdata,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_write_enable,
  output logic [THREAD_INDEX_BITS-1:0] out_thread_index,
  output logic [REG_INDEX_BITS-1:0]    out_reg_index,
  output logic [DATA_WIDTH-1:0]        out_data,
`ifdef MEM1_ALIGN_CHECK_EN
  output logic                         out_misaligned,
`endif
  output logic [STALL_COUNT_WIDTH-1:0] stall_count
);

  state_t                         state_r;
  logic                           req_valid_r;
  logic                           req_write_r;
  logic [ADDR_WIDTH-1:0]          req_addr_r;
  logic [DATA_WIDTH-1:0]          req_wdata_r;
  logic [THREAD_INDEX_BITS-1:0]   thread_index_r;
  logic [REG_INDEX_BITS-1:0]      reg_index_r;
  logic [STALL_COUNT_WIDTH-1:0]   stall_count_r;

  mem_op_t                        op_s;
  logic                           in_ready_s;
  logic                           accept_s;
  logic                           misaligned_s;
  logic                           res_load_s;
  logic                           res_write_enable_s;
  logic [THREAD_INDEX_BITS-1:0]   res_thread_index_s;
  logic [REG_INDEX_BITS-1:0]      res_reg_index_s;
  logic [DATA_WIDTH-1:0]          res_data_s;

  assign op_s       = decode_op(in_load_word_flag, in_store_word_flag);
  assign in_ready_s = (state_r == IDLE) && (!out_valid || out_ready);
  assign accept_s   = in_valid && in_ready_s;

`ifdef MEM1_ALIGN_CHECK_EN
  logic res_misaligned_s;
  assign misaligned_s     = (op_s != OP_ALU) &&
                            (in_data[WORD_OFFSET_BITS-1:0] != {WORD_OFFSET_BITS{1'b0}});
  // Only the IDLE accept path can produce a result while in IDLE.
  assign res_misaligned_s = (state_r == IDLE) && misaligned_s;
`else
  assign misaligned_s = 1'b0;
`endif

  // Select which event, if any, produces a result this cycle.
  always_comb begin
    res_load_s         = 1'b0;
    res_write_enable_s = 1'b0;
    res_thread_index_s = thread_index_r;
    res_reg_index_s    = reg_index_r;
    res_data_s         = {DATA_WIDTH{1'b0}};
    case (state_r)
      IDLE: begin
        if (accept_s && ((op_s == OP_ALU) || misaligned_s)) begin
          res_load_s         = 1'b1;
          res_write_enable_s = !misaligned_s;
          res_thread_index_s = in_thread_index;
          res_reg_index_s    = in_reg_index;
          res_data_s         = in_data;
        end else begin
          res_load_s = 1'b0;
        end
      end
      REQ: begin
        if (mem_req_ready && req_write_r) begin
          res_load_s = 1'b1;
        end else begin
          res_load_s = 1'b0;
        end
      end
      WAIT_RESP: begin
        if (mem_resp_valid) begin
          res_load_s         = 1'b1;
          res_write_enable_s = 1'b1;
          res_data_s         = mem_resp_rdata;
        end else begin
          res_load_s = 1'b0;
        end
      end
      default: begin
        res_load_s = 1'b0;
      end
    endcase
  end

  // Access FSM and the memory request registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= IDLE;
      req_valid_r    <= 1'b0;
      req_write_r    <= 1'b0;
      req_addr_r     <= {ADDR_WIDTH{1'b0}};
      req_wdata_r    <= {DATA_WIDTH{1'b0}};
      thread_index_r <= {THREAD_INDEX_BITS{1'b0}};
      reg_index_r    <= {REG_INDEX_BITS{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s && (op_s != OP_ALU) && !misaligned_s) begin
            state_r        <= REQ;
            req_valid_r    <= 1'b1;
            req_write_r    <= (op_s == OP_STORE);
            req_addr_r     <= in_data[ADDR_WIDTH+WORD_OFFSET_BITS-1:WORD_OFFSET_BITS];
            req_wdata_r    <= in_store_data;
            thread_index_r <= in_thread_index;
            reg_index_r    <= in_reg_index;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            req_valid_r <= 1'b0;
            state_r     <= req_write_r ? IDLE : WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (mem_resp_valid) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          req_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of cycles where upstream is held off.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count_r <= {STALL_COUNT_WIDTH{1'b0}};
    end else if (in_valid && !in_ready_s && (stall_count_r != {STALL_COUNT_WIDTH{1'b1}})) begin
      stall_count_r <= stall_count_r + {{(STALL_COUNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  mem1_result_register #(
    .DATA_WIDTH        (DATA_WIDTH),
    .REG_INDEX_BITS    (REG_INDEX_BITS),
    .THREAD_INDEX_BITS (THREAD_INDEX_BITS)
  ) u_result (
    .clk              (clk),
    .reset            (reset),
    .res_load         (res_load_s),
    .res_write_enable (res_write_enable_s),
    .res_thread_index (res_thread_index_s),
    .res_reg_index    (res_reg_index_s),
    .res_data         (res_data_s),
`ifdef MEM1_ALIGN_CHECK_EN
    .res_misaligned   (res_misaligned_s),
    .out_misaligned   (out_misaligned),
`endif
    .out_ready        (out_ready),
    .out_valid        (out_valid),
    .out_write_enable (out_write_enable),
    .out_thread_index (out_thread_index),
    .out_reg_index    (out_reg_index),
    .out_data         (out_data)
  );

  assign in_ready      = in_ready_s;
  assign mem_req_valid = req_valid_r;
  assign mem_req_write = req_write_r;
  assign mem_req_addr  = req_addr_r;
  assign mem_req_wdata = req_wdata_r;
  assign stall_count   = stall_count_r;

endmodule

// File: tb/tb_mem1_data_access.sv
// Directed bench for mem1_data_access; covers MEM1_ALIGN_CHECK_EN when defined.
module tb_mem1_data_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_load_word_flag, in_store_word_flag;
  logic [2:0]  in_thread_index;
  logic [4:0]  in_reg_index;
  logic [63:0] in_data, in_store_data;
  logic        mem_req_valid, mem_req_ready, mem_req_write;
  logic [9:0]  mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;
  logic        out_valid, out_ready, out_write_enable;
  logic [2:0]  out_thread_index;
  logic [4:0]  out_reg_index;
  logic [63:0] out_data;
  logic [31:0] stall_count;
`ifdef MEM1_ALIGN_CHECK_EN
  logic        out_misaligned;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_stall = 32'd0;

  always #5 clk = ~clk;

  mem1_data_access dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_load_word_flag(in_load_word_flag), .in_store_word_flag(in_store_word_flag),
    .in_thread_index(in_thread_index), .in_reg_index(in_reg_index),
    .in_data(in_data), .in_store_data(in_store_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_write_enable(out_write_enable),
    .out_thread_index(out_thread_index), .out_reg_index(out_reg_index), .out_data(out_data),
`ifdef MEM1_ALIGN_CHECK_EN
    .out_misaligned(out_misaligned),
`endif
    .stall_count(stall_count)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_load_word_flag = 1'b0; in_store_word_flag = 1'b0;
  endtask

  task automatic flush();
    idle_inputs();
    step(); step();
  endtask

  task automatic test_reset();
    reset = 1'b0; idle_inputs();
    in_thread_index = 3'd0; in_reg_index = 5'd0; in_data = 64'd0; in_store_data = 64'd0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 64'd0; out_ready = 1'b1;
    step(); step();
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", mem_req_valid); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (stall_count !== 32'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_count); end
    checks++; if ({out_data, mem_req_addr, mem_req_wdata} !== {64'd0, 10'd0, 64'd0}) begin errors++; $display("FAIL reset_data: out_data %h addr %h wdata %h want 0", out_data, mem_req_addr, mem_req_wdata); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_alu();
    flush();
    in_valid = 1'b1; in_thread_index = 3'd2; in_reg_index = 5'd7; in_data = 64'h1234; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL alu_in_ready: got %b want 1", in_ready); end
    step(); idle_inputs();
    checks++; if ({out_valid, out_write_enable, out_data} !== {1'b1, 1'b1, 64'h1234}) begin errors++; $display("FAIL alu_result: valid %b we %b data %h want 1 1 1234", out_valid, out_write_enable, out_data); end
    checks++; if ({out_reg_index, out_thread_index} !== {5'd7, 3'd2}) begin errors++; $display("FAIL alu_index: reg %0d thr %0d want 7 2", out_reg_index, out_thread_index); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL alu_no_req: got %b want 0", mem_req_valid); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL alu_clear: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] vals [3];
    vals[0] = 64'h11; vals[1] = 64'h22; vals[2] = 64'h33;
    flush();
    out_ready = 1'b1; in_valid = 1'b1; in_data = vals[0]; in_reg_index = 5'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (i < 2) begin in_data = vals[i+1]; end else begin in_valid = 1'b0; end
      checks++; if ({out_valid, out_data} !== {1'b1, vals[i]}) begin errors++; $display("FAIL b2b_%0d: valid %b data %h want 1 %h", i, out_valid, out_data, vals[i]); end
    end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_clear: got %b want 0", out_valid); end
  endtask

  task automatic test_load();
    flush();
    in_valid = 1'b1; in_load_word_flag = 1'b1; in_store_word_flag = 1'b1;
    in_data = 64'h40; in_reg_index = 5'd4; in_thread_index = 3'd6; mem_req_ready = 1'b1;
    step(); idle_inputs();
    checks++; if ({mem_req_valid, mem_req_write, mem_req_addr} !== {1'b1, 1'b0, 10'd8}) begin errors++; $display("FAIL load_req: valid %b write %b addr %0d want 1 0 8", mem_req_valid, mem_req_write, mem_req_addr); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL load_ready_req: got %b want 0", in_ready); end
    step();
    checks++; if ({mem_req_valid, in_ready, out_valid} !== 3'b000) begin errors++; $display("FAIL load_wait: req %b in_ready %b out_valid %b want 000", mem_req_valid, in_ready, out_valid); end
    step();
    mem_resp_valid = 1'b1; mem_resp_rdata = 64'hDEADBEEF;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL load_ready_wait: got %b want 0", in_ready); end
    step(); mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
    checks++; if ({out_valid, out_write_enable, out_data} !== {1'b1, 1'b1, 64'hDEADBEEF}) begin errors++; $display("FAIL load_result: valid %b we %b data %h want 1 1 deadbeef", out_valid, out_write_enable, out_data); end
    checks++; if ({out_reg_index, out_thread_index} !== {5'd4, 3'd6}) begin errors++; $display("FAIL load_index: reg %0d thr %0d want 4 6", out_reg_index, out_thread_index); end
  endtask

  task automatic test_store();
    flush();
    in_valid = 1'b1; in_store_word_flag = 1'b1; in_data = 64'h18; in_store_data = 64'h55;
    in_reg_index = 5'd3; in_thread_index = 3'd5; mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 3) mem_req_ready = 1'b1;
      checks++; if ({mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata} !== {1'b1, 1'b1, 10'd3, 64'h55}) begin errors++; $display("FAIL store_hold_%0d: valid %b write %b addr %0d wdata %h want 1 1 3 55", i, mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL store_ready_%0d: got %b want 0", i, in_ready); end
    end
    step(); idle_inputs(); mem_req_ready = 1'b0;
    exp_stall = exp_stall + 32'd4;
    checks++; if ({mem_req_valid, out_valid, out_write_enable, out_data} !== {1'b0, 1'b1, 1'b0, 64'd0}) begin errors++; $display("FAIL store_result: req %b valid %b we %b data %h want 0 1 0 0", mem_req_valid, out_valid, out_write_enable, out_data); end
    checks++; if (out_reg_index !== 5'd3) begin errors++; $display("FAIL store_reg: got %0d want 3", out_reg_index); end
    checks++; if (stall_count !== exp_stall) begin errors++; $display("FAIL store_stall: got %0d want %0d", stall_count, exp_stall); end
  endtask

  task automatic test_backpressure();
    flush();
    in_valid = 1'b1; in_data = 64'hABCD; in_reg_index = 5'd9; in_thread_index = 3'd1; out_ready = 1'b0;
    step(); in_data = 64'h9999;
    #1;
    checks++; if ({out_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL bp_start: valid %b in_ready %b want 1 0", out_valid, in_ready); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if ({out_valid, out_data, out_reg_index, in_ready} !== {1'b1, 64'hABCD, 5'd9, 1'b0}) begin errors++; $display("FAIL bp_hold_%0d: valid %b data %h reg %0d in_ready %b want 1 abcd 9 0", i, out_valid, out_data, out_reg_index, in_ready); end
    end
    exp_stall = exp_stall + 32'd5;
    checks++; if (stall_count !== exp_stall) begin errors++; $display("FAIL bp_stall: got %0d want %0d", stall_count, exp_stall); end
    idle_inputs(); out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_clear: got %b want 0", out_valid); end
  endtask

  task automatic test_misaligned();
    flush();
    in_valid = 1'b1; in_load_word_flag = 1'b1; in_data = 64'h41; in_reg_index = 5'd2; mem_req_ready = 1'b1;
    step(); idle_inputs();
`ifdef MEM1_ALIGN_CHECK_EN
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL mis_no_req: got %b want 0", mem_req_valid); end
    checks++; if ({out_valid, out_misaligned, out_write_enable, out_data} !== {1'b1, 1'b1, 1'b0, 64'h41}) begin errors++; $display("FAIL mis_result: valid %b mis %b we %b data %h want 1 1 0 41", out_valid, out_misaligned, out_write_enable, out_data); end
    in_valid = 1'b1; in_data = 64'h10;
    step(); idle_inputs();
    checks++; if ({out_valid, out_misaligned, out_write_enable} !== 3'b101) begin errors++; $display("FAIL mis_alu_clear: valid %b mis %b we %b want 1 0 1", out_valid, out_misaligned, out_write_enable); end
`else
    checks++; if ({mem_req_valid, mem_req_addr} !== {1'b1, 10'd8}) begin errors++; $display("FAIL unal_req: valid %b addr %0d want 1 8", mem_req_valid, mem_req_addr); end
    step();
    mem_resp_valid = 1'b1; mem_resp_rdata = 64'h77;
    step(); mem_resp_valid = 1'b0;
    checks++; if ({out_valid, out_write_enable, out_data} !== {1'b1, 1'b1, 64'h77}) begin errors++; $display("FAIL unal_result: valid %b we %b data %h want 1 1 77", out_valid, out_write_enable, out_data); end
`endif
    mem_req_ready = 1'b0;
  endtask

  task automatic test_reset_mid_req();
    flush();
    in_valid = 1'b1; in_load_word_flag = 1'b1; in_data = 64'h80; mem_req_ready = 1'b0;
    step(); idle_inputs();
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got %b want 1", mem_req_valid); end
    reset = 1'b0;
    #1;
    checks++; if ({mem_req_valid, stall_count} !== {1'b0, 32'd0}) begin errors++; $display("FAIL rst_mid_async: req %b stall %0d want 0 0", mem_req_valid, stall_count); end
    #1; reset = 1'b1; exp_stall = 32'd0;
    step();
    mem_resp_valid = 1'b1; mem_resp_rdata = 64'h5A;
    step(); mem_resp_valid = 1'b0;
    checks++; if ({out_valid, mem_req_valid, in_ready} !== 3'b001) begin errors++; $display("FAIL rst_mid_late_resp: valid %b req %b in_ready %b want 0 0 1", out_valid, mem_req_valid, in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_quiet: got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_load();
    test_store();
    test_backpressure();
    test_misaligned();
    test_reset_mid_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem1_data_access.md
Name: mem1_data_access

Overview:
- MEM1 stage of the 5-stage multithreaded pipeline. It consumes the EX2/MEM1 pipeline register outputs and performs the data-memory access for load/store ops.
- Issues a valid/ready request to data memory and waits for load data.
- Stalls upstream while an access or an unaccepted result is outstanding.
- Presents one result per instruction to MEM2/WB through a registered valid/ready output.

Parameters:
- DATA_WIDTH, 64, register/data word width
- REG_INDEX_BITS, 5, destination register index width
- THREAD_INDEX_BITS, 3, hardware thread id width
- ADDR_WIDTH, 10, data-memory word-address width
- STALL_COUNT_WIDTH, 32, stall performance counter width

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept this cycle
- in_load_word_flag  in  1  instruction is a load
- in_store_word_flag  in  1  instruction is a store
- in_thread_index  in  THREAD_INDEX_BITS  issuing thread
- in_reg_index  in  REG_INDEX_BITS  destination register
- in_data  in  DATA_WIDTH  ALU result, or byte address for load/store
- in_store_data  in  DATA_WIDTH  store data
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_write  out  1  1 = store, 0 = load
- mem_req_addr  out  ADDR_WIDTH  word address = in_data[ADDR_WIDTH+2:3]
- mem_req_wdata  out  DATA_WIDTH  store data
- mem_resp_valid  in  1  load data valid
- mem_resp_rdata  in  DATA_WIDTH  load data
- out_valid  out  1  result valid to MEM2
- out_ready  in  1  MEM2 accepts result
- out_write_enable  out  1  result writes register file
- out_thread_index  out  THREAD_INDEX_BITS  thread of result
- out_reg_index  out  REG_INDEX_BITS  destination of result
- out_data  out  DATA_WIDTH  ALU pass-through or load data
- stall_count  out  STALL_COUNT_WIDTH  saturating count of stall cycles

Behaviour:
- Reset (async, reset==0):
  - State = IDLE.
  - mem_req_valid, mem_req_write, out_valid, out_write_enable = 0.
  - mem_req_addr, mem_req_wdata, out_data, out_thread_index, out_reg_index = 0.
  - stall_count = 0.
- FSM states: IDLE, REQ, WAIT_RESP.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Acceptance = in_valid && in_ready.
- Operation priority: load when in_load_word_flag=1; otherwise store when in_store_word_flag=1; otherwise ALU op. Load wins if both flags are set.
- ALU op:
  - Registered 1-cycle latency.
  - Next cycle: out_valid=1, out_data=in_data, out_write_enable=1; thread and reg index are passed through.
- Load/store on acceptance:
  - Capture thread/reg index, address and wdata.
  - Go to REQ; mem_req_valid=1 from the next cycle.
  - Address and write stay stable while mem_req_valid && !mem_req_ready.
- REQ with mem_req_ready=1:
  - mem_req_valid drops next cycle.
  - Store: out_valid=1 next cycle, out_write_enable=0, out_data=0, then back to IDLE.
  - Load: go to WAIT_RESP.
- WAIT_RESP with mem_resp_valid=1:
  - Next cycle: out_valid=1, out_data=mem_resp_rdata, out_write_enable=1; back to IDLE.
- Response timing rules:
  - Responses arrive at the earliest one cycle after the request handshake.
  - mem_resp_valid outside WAIT_RESP is ignored.
  - Exactly one response per load.
- Output holding: out_* hold while out_valid && !out_ready. out_valid clears when out_ready=1 and no new result is produced that cycle.
- Back-to-back ALU ops with out_ready=1 sustain 1 result/cycle. Each memory op occupies at least 2 cycles (store) or at least 3 cycles (load).
- stall_count increments on every cycle with in_valid && !in_ready and saturates at all-ones.
- Reset mid-access drops the outstanding request. A late response after reset is ignored because state is IDLE.

Optional Feature:
- Macro: MEM1_ALIGN_CHECK_EN.
- Defined:
  - Adds output port out_misaligned (1 bit, reset 0).
  - A load/store with in_data[2:0]!=0 issues no memory request.
  - The result is produced 1 cycle after acceptance with out_misaligned=1, out_write_enable=0, out_data=in_data.
  - out_misaligned=0 for all other results.
- Undefined: no port; address bits [2:0] are ignored and the access proceeds normally.

Decomposition:
- Shared package mem1_pkg:
  - state enum (IDLE, REQ, WAIT_RESP);
  - WORD_OFFSET_BITS=3 constant;
  - a mem-op encoding (OP_ALU, OP_LOAD, OP_STORE) with the priority rule.
- One natural sub-module: mem1_result_register, the valid/ready holding register for out_*.

Test Plan:
- Reset asserted mid-REQ (mem_req_valid=1) → mem_req_valid=0 immediately; a later mem_resp_valid=1 produces no out_valid.
- ALU op: in_data=0x1234, reg 7, thread 2, out_ready=1 → next cycle out_valid=1, out_data=0x1234, out_write_enable=1, reg 7, thread 2.
- Load: in_data=0x40, mem_req_ready=1, response 2 cycles later with rdata=0xDEADBEEF → mem_req_addr=8, mem_req_write=0; out_data=0xDEADBEEF with out_write_enable=1; in_ready=0 throughout.
- Store: in_data=0x18, in_store_data=0x55, mem_req_ready low 3 cycles → mem_req_valid, addr=3 and wdata=0x55 held stable; after the handshake out_valid=1 with out_write_enable=0; stall_count rises by 4 if in_valid was held.
- Backpressure: out_ready=0 for 5 cycles after an ALU result → outputs stable, in_ready=0, stall_count +5 with in_valid=1.
- MEM1_ALIGN_CHECK_EN: load with in_data=0x41 → no mem_req_valid; next cycle out_misaligned=1, out_write_enable=0.
